uart_block_tx: RTL
==================

Name: uart_block_tx

Overview:
- Transmit end of the host link: accepts one 128-bit AES result block per write handshake and serialises it as 16 UART frames on a single TX line.
- Driven by the AES control block's TX-side interface (block data + space indication).
- One-deep holding register plus a shift engine, so the next block can be accepted while the current one is on the wire.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- d_in  input  128  block to transmit
- wr_en  input  1  write strobe; accepted only when has_space=1
- has_space  output  1  holding register empty; write will be accepted
- tx  output  1  UART serial line, idle high
- busy  output  1  shift engine sending a block
- done  output  1  one-cycle pulse after last stop bit of a block

Behaviour:
- Reset, asynchronous and active-high, sets:
  - Outputs: tx=1, has_space=1, busy=0, done=0.
  - Internal state: hold_valid=0, FSM=IDLE, all counters=0.
- Reset mid-frame: frame abandoned, tx returns to 1 immediately, and any held block is discarded.
- Write handshake:
  - wr_en && has_space captures d_in into the holding register; hold_valid=1 and has_space=0 from the next cycle.
  - wr_en while has_space=0 is ignored; holding contents are unchanged.
  - has_space is registered and equals !hold_valid.
- Engine load:
  - Condition: FSM in IDLE, or finishing the last stop bit of the last byte, with hold_valid=1.
  - Holding register is copied to the shift buffer and hold_valid clears.
  - has_space=1 in the following cycle.
- Byte order: d_in[127:120] sent first, d_in[7:0] last.
- Bit order within a byte: LSB first.
- Frame format: start bit 0, 8 data bits, [parity], stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, PARITY (only if feature enabled), STOP.
  - IDLE -> START on load.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> (PARITY or STOP) after 8 bit times.
  - STOP -> START if bytes remain.
  - STOP after byte 15 -> START if hold_valid, else IDLE.
- Back-to-back operation: no idle bits between bytes or between consecutive blocks.
- Counters:
  - Baud counter, width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit index 0..7.
  - Byte index 0..15; wraps to 0 on block load.
- Latency: tx falls (start bit) 2 cycles after the accepting wr_en edge when the engine is idle.
- busy: 1 from the first start-bit cycle through the final stop bit, otherwise 0.
- done: asserted the cycle after the last stop bit of each block ends, then deasserted. It pulses once per block even when the next block starts immediately.
- Block time: 16 × 10 × CLKS_PER_BIT cycles (16 × 11 × CLKS_PER_BIT with parity).
- Simultaneous wr_en and engine load in the same cycle:
  - has_space is still 0 that cycle, so the write is ignored.
  - The writer must retry once has_space=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between the last data bit and the stop bit. The frame is 11 bits; the PARITY state exists.
- Undefined: no parity bit, 10-bit frame, no PARITY state or logic synthesised.

Test Plan (CLKS_PER_BIT=4):
- Reset: assert reset for 3 cycles -> tx=1, has_space=1, busy=0, done=0. Outputs hold these values with no writes for 100 cycles.
- Single block:
  - Stimulus: write 128'h000102030405060708090A0B0C0D0E0F.
  - Required: line decodes to bytes 00,01,...,0F in that order.
  - tx falls 2 cycles after write; done pulses exactly 640 cycles after the first start bit begins; busy=0 afterwards.
- Back-to-back:
  - Stimulus: write block A (all 0xAA); write block B (all 0x55) at cycle 50.
  - Required: has_space=0 from cycle 51 until A's last stop bit ends.
  - B's first start bit immediately follows A's last stop bit, with no idle bit.
  - done pulses twice, 640 cycles apart.
- Write while full:
  - Stimulus: write A, write B, then write C (0xFF..FF) while has_space=0.
  - Required: C is not transmitted; only A then B appear on the line.
- Reset mid-operation:
  - Stimulus: reset asserted during byte 5 of a block with a second block held.
  - Required: tx=1 without waiting for a clock edge, has_space=1, busy=0.
  - A new write of 128'h1 afterwards transmits 15 bytes of 00 then 01, cleanly framed.
- Parity (UART_TX_PARITY_EN defined):
  - Stimulus: block whose first byte is 0x07.
  - Required: parity bit 1 for that byte; 0 for byte 0x03; block time 704 cycles.

Source files
------------

// File: rtl/uart_block_tx.sv
// 128-bit block UART transmitter: one-deep holding register feeding a 16-byte shift engine.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_block_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] d_in,
  input  logic         wr_en,
  output logic         has_space,
  output logic         tx,
  output logic         busy,
  output logic         done
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t         state, state_n;
  logic [127:0]   hold_buf, shift_buf;
  logic           hold_valid;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [3:0]     byte_idx;
  logic [7:0]     cur_byte;
  logic           bit_end, blk_end, load, tx_n;
  logic [1:0]     done_pipe;

  assign cur_byte  = shift_buf[127:120];
  assign bit_end   = (baud_cnt == BAUD_MAX);
  assign blk_end   = (state == STOP) && bit_end && (byte_idx == 4'd15);
  assign load      = hold_valid && ((state == IDLE) || blk_end);
  assign has_space = !hold_valid;
  assign done      = done_pipe[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    tx_n    = 1'b1;
    case (state)
      IDLE:  if (load) state_n = START;
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = cur_byte[bit_idx];
`ifdef UART_TX_PARITY_EN
        if (bit_end && bit_idx == 3'd7) state_n = PARITY;
`else
        if (bit_end && bit_idx == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_n = ^cur_byte;
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        // Chaining straight into START keeps bytes and blocks gap-free.
        if (bit_end) state_n = (byte_idx != 4'd15 || hold_valid) ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_buf   <= '0;
      hold_valid <= 1'b0;
      shift_buf  <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done_pipe  <= '0;
    end else begin
      // load needs hold_valid=1 and a write needs it 0, so they never collide.
      if (load) begin
        hold_valid <= 1'b0;
      end else if (wr_en && !hold_valid) begin
        hold_buf   <= d_in;
        hold_valid <= 1'b1;
      end
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
      if (load) begin
        shift_buf <= hold_buf;
        byte_idx  <= '0;
      end else if (state == STOP && bit_end) begin
        shift_buf <= {shift_buf[119:0], 8'h00};
        byte_idx  <= byte_idx + 4'd1;
      end
      // Line outputs lag the FSM by one cycle; done lags one more to follow the final stop bit.
      tx        <= tx_n;
      busy      <= (state != IDLE);
      done_pipe <= {done_pipe[0], blk_end};
    end
  end
endmodule
